curl_transform: RTL and testbench



---
 rtl/curl_transform_if.sv | 21 ++
 rtl/curl_transform.sv | 169 ++++++++++++++++
 tb/tb_curl_transform.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/curl_transform_if.sv
// curl_transform_if
//   Bundles the transform request/response signals between the sponge
//   controller and the Curl-P permutation engine.
//   start     : transform request, honoured only while busy = 0
//   state_in  : 729-trit input state, trit i at bits [2i+1:2i]
//   busy      : transform in progress
//   done      : one-cycle pulse when state_out holds the result
//   state_out : engine state register, valid while busy = 0
//   Modports: master = sponge controller side, slave = engine side.
interface curl_transform_if;
  logic          start;
  logic [1457:0] state_in;
  logic          busy;
  logic          done;
  logic [1457:0] state_out;

  modport master (output start, output state_in,
                  input  busy,  input  done, input state_out);
  modport slave  (input  start, input  state_in,
                  output busy,  output done, output state_out);
endinterface

// File: rtl/curl_transform.sv
// curl_transform
//   Iterative Curl-P permutation engine. Holds the 729-trit sponge state and
//   applies one full round per clock through 729 parallel truth_table
//   lookups. After NUM_ROUNDS rounds the permuted state is presented with a
//   one-cycle done pulse.
//   Ports:
//     clk      : system clock
//     reset    : asynchronous, active-high reset
//     cb       : curl_transform_if.slave (start, state_in, busy, done,
//                state_out)
//     trit_err : sticky flag, set when a 2'b10 trit is loaded (only when
//                CURL_TRIT_CHECK_EN is defined)
//   Parameter NUM_ROUNDS: rounds per transform, 1..255.
//   Optional feature macro: CURL_TRIT_CHECK_EN.
//   Trit encoding: 2'b01 = +1, 2'b00 = 0, 2'b11 = -1; 2'b10 becomes 0 on load.

// truth_table: Curl-P substitution, sel 0..8 -> +1,0,-1,+1,-1,0,-1,+1,0.
module truth_table (
  input  logic [3:0] sel,
  output logic [1:0] trit
);
  // Substitution lookup; out-of-range selectors map to 0.
  always_comb begin
    trit = 2'b00;
    case (sel)
      4'd0:    trit = 2'b01;
      4'd1:    trit = 2'b00;
      4'd2:    trit = 2'b11;
      4'd3:    trit = 2'b01;
      4'd4:    trit = 2'b11;
      4'd5:    trit = 2'b00;
      4'd6:    trit = 2'b11;
      4'd7:    trit = 2'b01;
      4'd8:    trit = 2'b00;
      default: trit = 2'b00;
    endcase
  end
endmodule

module curl_transform #(
  parameter int unsigned NUM_ROUNDS = 81
) (
  input  logic              clk,
  input  logic              reset,
  curl_transform_if.slave   cb
`ifdef CURL_TRIT_CHECK_EN
  ,
  output logic              trit_err
`endif
);
  localparam int          NUM_TRITS  = 729;
  localparam int          STATE_W    = 2 * NUM_TRITS;
  localparam logic [7:0]  LAST_ROUND = 8'(NUM_ROUNDS - 1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} fsm_e;

  fsm_e               fsm_q,   fsm_d;
  logic [7:0]         round_q, round_d;
  logic               done_q,  done_d;
  logic [STATE_W-1:0] st_q,    st_d;
  logic [STATE_W-1:0] load_s;   // state_in with 2'b10 trits forced to 0
  logic [STATE_W-1:0] round_s;  // st_q after one round

`ifdef CURL_TRIT_CHECK_EN
  logic [NUM_TRITS-1:0] bad_s;
  logic                 err_q, err_d;
`endif

  for (genvar i = 0; i < NUM_TRITS; i++) begin : g_trit
    // The walk idx_{k+1} = idx_k + 364 (or - 365 past 364) is simply
    // (idx_k + 364) mod 729, so idx_k = 364*k mod 729 in closed form.
    localparam int IDX_A = (364 * i) % 729;
    localparam int IDX_B = (364 * (i + 1)) % 729;

    logic [1:0] in_s;
    logic [1:0] a_s;
    logic [1:0] b_s;
    logic [3:0] sel_s;

    assign in_s               = cb.state_in[2*i +: 2];
    assign load_s[2*i +: 2]   = (in_s == 2'b10) ? 2'b00 : in_s;
`ifdef CURL_TRIT_CHECK_EN
    assign bad_s[i]           = (in_s == 2'b10);
`endif
    assign a_s = st_q[2*IDX_A +: 2];
    assign b_s = st_q[2*IDX_B +: 2];
    // Sign-extended 4-bit sum wraps mod 16, giving a + 3b + 4 in 0..8.
    assign sel_s = {{2{a_s[1]}}, a_s} + 4'd3 * {{2{b_s[1]}}, b_s} + 4'd4;

    truth_table u_tt (
      .sel  (sel_s),
      .trit (round_s[2*i +: 2])
    );
  end

  // Next-state logic: load on accepted start, one round per RUN cycle.
  always_comb begin
    fsm_d   = fsm_q;
    round_d = round_q;
    st_d    = st_q;
    done_d  = 1'b0;
    case (fsm_q)
      IDLE: begin
        if (cb.start) begin
          fsm_d   = RUN;
          round_d = 8'd0;
          st_d    = load_s;
        end else begin
          fsm_d   = IDLE;
        end
      end
      RUN: begin
        st_d    = round_s;
        round_d = round_q + 8'd1;
        if (round_q == LAST_ROUND) begin
          fsm_d  = IDLE;
          done_d = 1'b1;
        end else begin
          fsm_d  = RUN;
        end
      end
      default: begin
        fsm_d = IDLE;
      end
    endcase
  end

`ifdef CURL_TRIT_CHECK_EN
  // Sticky error: set by any invalid trit captured on an accepted start.
  always_comb begin
    err_d = err_q;
    if ((fsm_q == IDLE) && cb.start && (|bad_s)) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
  end

  // Error flag register, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign trit_err = err_q;
`endif

  // Control and state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm_q   <= IDLE;
      round_q <= 8'd0;
      done_q  <= 1'b0;
      st_q    <= {STATE_W{1'b0}};
    end else begin
      fsm_q   <= fsm_d;
      round_q <= round_d;
      done_q  <= done_d;
      st_q    <= st_d;
    end
  end

  assign cb.busy      = (fsm_q == RUN);
  assign cb.done      = done_q;
  assign cb.state_out = st_q;
endmodule

// File: tb/tb_curl_transform.sv
// tb_curl_transform
//   Self-checking bench for curl_transform. Three instances (1, 2 and 81
//   rounds) run against a behavioural Curl-P model that walks the index
//   sequence step by step and looks trits up in a 9-entry table.
//   Also exercises CURL_TRIT_CHECK_EN when that macro is defined.
module tb_curl_transform;
  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  curl_transform_if if1();
  curl_transform_if if2();
  curl_transform_if if81();

`ifdef CURL_TRIT_CHECK_EN
  logic err1, err2, err81;
`endif

  curl_transform #(.NUM_ROUNDS(1)) u_dut1 (
    .clk(clk), .reset(reset), .cb(if1)
`ifdef CURL_TRIT_CHECK_EN
    , .trit_err(err1)
`endif
  );
  curl_transform #(.NUM_ROUNDS(2)) u_dut2 (
    .clk(clk), .reset(reset), .cb(if2)
`ifdef CURL_TRIT_CHECK_EN
    , .trit_err(err2)
`endif
  );
  curl_transform #(.NUM_ROUNDS(81)) u_dut81 (
    .clk(clk), .reset(reset), .cb(if81)
`ifdef CURL_TRIT_CHECK_EN
    , .trit_err(err81)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare, count, and report the first differing trit on a mismatch.
  task automatic check_val(input string tag, input logic [1457:0] act,
                           input logic [1457:0] exp);
    int d;
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      d = -1;
      for (int i = 728; i >= 0; i--)
        if (act[2*i +: 2] !== exp[2*i +: 2]) d = i;
      $display("FAIL %s: actual %0h required %0h (low 64 bits), first differing trit %0d",
               tag, act[63:0], exp[63:0], d);
    end
  endtask

  // Behavioural Curl-P: trits as integers, index walk as stated rule.
  function automatic logic [1457:0] curl_model(input logic [1457:0] st, input int rounds);
    int s[729];
    int t[729];
    int tt[9];
    int idx, nidx;
    logic [1457:0] r;
    tt = '{1, 0, -1, 1, -1, 0, -1, 1, 0};
    for (int i = 0; i < 729; i++)
      s[i] = (st[2*i +: 2] == 2'b01) ? 1 : (st[2*i +: 2] == 2'b11) ? -1 : 0;
    for (int rd = 0; rd < rounds; rd++) begin
      t   = s;
      idx = 0;
      for (int i = 0; i < 729; i++) begin
        nidx = (idx < 365) ? idx + 364 : idx - 365;
        s[i] = tt[t[idx] + 3 * t[nidx] + 4];
        idx  = nidx;
      end
    end
    for (int i = 0; i < 729; i++)
      r[2*i +: 2] = (s[i] == 1) ? 2'b01 : (s[i] == -1) ? 2'b11 : 2'b00;
    return r;
  endfunction

  function automatic logic [1457:0] rand_state(input bit allow_bad);
    logic [1457:0] r;
    logic [1:0]    c;
    for (int i = 0; i < 729; i++) begin
      c = 2'($urandom_range(0, 3));
      if (!allow_bad && c == 2'b10) c = 2'b00;
      r[2*i +: 2] = c;
    end
    return r;
  endfunction

  task automatic set_in(input int which, input logic s, input logic [1457:0] st);
    case (which)
      1:       begin if1.start = s;  if1.state_in = st;  end
      2:       begin if2.start = s;  if2.state_in = st;  end
      default: begin if81.start = s; if81.state_in = st; end
    endcase
  endtask

  task automatic set_start(input int which, input logic s);
    case (which)
      1:       if1.start = s;
      2:       if2.start = s;
      default: if81.start = s;
    endcase
  endtask

  function automatic logic get_done(input int which);
    case (which)
      1:       return if1.done;
      2:       return if2.done;
      default: return if81.done;
    endcase
  endfunction

  function automatic logic get_busy(input int which);
    case (which)
      1:       return if1.busy;
      2:       return if2.busy;
      default: return if81.busy;
    endcase
  endfunction

  function automatic logic [1457:0] get_state(input int which);
    case (which)
      1:       return if1.state_out;
      2:       return if2.state_out;
      default: return if81.state_out;
    endcase
  endfunction

  // One transform; lat counts edges from the accepting edge to done.
  task automatic run_xfer(input int which, input logic [1457:0] st,
                          output logic [1457:0] res, output int lat);
    int cyc;
    cyc = 0;
    set_in(which, 1'b1, st);
    do begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) begin
        set_start(which, 1'b0);
        check_val("busy_set", get_busy(which), 1'b1);
      end
    end while (!get_done(which) && cyc < 300);
    lat = cyc;
    res = get_state(which);
    @(posedge clk); #1;
    check_val("done_pulse", get_done(which), 1'b0);
  endtask

  initial begin
    logic [1457:0] st, st_b, res, zero_st, ones_st;
    int lat, c, d1, d2, n_done;
    n_tests = 0;
    n_fail  = 0;
    zero_st = '0;
    ones_st = '1;
    reset = 1'b1;
    set_in(1, 1'b0, zero_st);
    set_in(2, 1'b0, zero_st);
    set_in(81, 1'b0, zero_st);
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_busy", get_busy(81), 1'b0);
    check_val("rst_done", get_done(81), 1'b0);
    check_val("rst_state", get_state(81), zero_st);
`ifdef CURL_TRIT_CHECK_EN
    check_val("rst_err", err81, 1'b0);
`endif
    reset = 1'b0;

    // Single round on zeros: every sel = 4, result all -1.
    run_xfer(1, zero_st, res, lat);
    check_val("lat1", lat, 2);
    check_val("r1_all_minus1", res, ones_st);
    check_val("r1_model", res, curl_model(zero_st, 1));

    // Two rounds on zeros: all +1.
    run_xfer(2, zero_st, res, lat);
    check_val("lat2", lat, 3);
    check_val("r2_model", res, curl_model(zero_st, 2));

    // 81 rounds on zeros: period 3, back to zeros.
    run_xfer(81, zero_st, res, lat);
    check_val("lat81_zero", lat, 82);
    check_val("r81_zero", res, zero_st);

    // Random vectors, including invalid 2'b10 codes when the check is off.
`ifdef CURL_TRIT_CHECK_EN
    for (int v = 0; v < 100; v++) begin
      st = rand_state(1'b0);
`else
    for (int v = 0; v < 100; v++) begin
      st = rand_state(1'b1);
`endif
      run_xfer(81, st, res, lat);
      check_val("lat81", lat, 82);
      check_val("rand81", res, curl_model(st, 81));
    end

    // start held high: back-to-back transforms, mid-run state_in ignored.
    st   = rand_state(1'b0);
    st_b = rand_state(1'b0);
    set_in(81, 1'b1, st);
    c = 0; d1 = -1; d2 = -1;
    while (c < 400 && d2 < 0) begin
      @(posedge clk); #1;
      c++;
      if (c == 5) if81.state_in = st_b;
      if (d1 > 0 && c == d1 + 1) check_val("b2b_busy", get_busy(81), 1'b1);
      if (get_done(81)) begin
        if (d1 < 0) begin
          d1 = c;
          check_val("b2b_first", get_state(81), curl_model(st, 81));
        end else begin
          d2 = c;
          set_start(81, 1'b0);
          check_val("b2b_second", get_state(81), curl_model(st_b, 81));
        end
      end
    end
    set_start(81, 1'b0);
    check_val("b2b_d1", d1, 82);
    check_val("b2b_d2", d2, 164);
    @(posedge clk); #1;

    // Reset at round 40: immediate clear, no done afterwards.
    st = rand_state(1'b0);
    set_in(81, 1'b1, st);
    n_done = 0;
    for (int i = 0; i < 41; i++) begin
      @(posedge clk); #1;
      set_start(81, 1'b0);
      if (get_done(81)) n_done++;
    end
    reset = 1'b1;
    #1;
    check_val("mid_rst_busy", get_busy(81), 1'b0);
    check_val("mid_rst_state", get_state(81), zero_st);
    check_val("mid_rst_done", get_done(81), 1'b0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (get_done(81)) n_done++;
    end
    check_val("mid_rst_no_done", n_done, 0);
    run_xfer(81, st, res, lat);
    check_val("post_rst_lat", lat, 82);
    check_val("post_rst_res", res, curl_model(st, 81));

`ifdef CURL_TRIT_CHECK_EN
    // Invalid trit 5: flag sets on load, result as if trit 5 were 0.
    check_val("err_clear", err81, 1'b0);
    st = rand_state(1'b0);
    st_b = st;
    st[11:10] = 2'b10;
    st_b[11:10] = 2'b00;
    set_in(81, 1'b1, st);
    c = 0;
    do begin
      @(posedge clk); #1;
      c++;
      if (c == 1) begin
        set_start(81, 1'b0);
        check_val("err_set", err81, 1'b1);
      end
    end while (!get_done(81) && c < 300);
    check_val("err_lat", c, 82);
    check_val("err_res", get_state(81), curl_model(st_b, 81));
    run_xfer(81, rand_state(1'b0), res, lat);
    check_val("err_sticky", err81, 1'b1);
    reset = 1'b1;
    #1;
    check_val("err_rst", err81, 1'b0);
    @(negedge clk);
    reset = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
